// File: rtl/tx_intf_s_axis_to_pl_if.sv
// AXI-stream bundle carrying DMA words from the PS into the TX stream block.
// The master drives data/valid/last and the slave returns ready.
interface tx_intf_s_axis_to_pl_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/tx_intf_s_axis_to_pl.sv
// DMA stream to TX buffer: parses the two-word header, forwards payload with backpressure,
// checks length, recovers hung transfers by timeout, and raises a delayed TX-done interrupt.
module tx_intf_s_axis_to_pl #(
    parameter int C_S00_AXIS_TDATA_WIDTH = 64,
    parameter int MAX_BIT_NUM_DMA_SYMBOL = 14
) (
    input  logic                              clk,
    input  logic                              rstn,
    tx_intf_s_axis_to_pl_if.slave             s_axis,
    output logic [C_S00_AXIS_TDATA_WIDTH-1:0] data_to_acc,
    output logic                              data_valid_to_acc,
    input  logic                              acc_ready,
    output logic [15:0]                       pkt_len,
    output logic [7:0]                        pkt_rate,
    output logic                              ht_sgi,
    output logic                              header_valid,
    output logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] num_dma_symbol_expected,
    output logic                              len_err,
    output logic                              s_axis_rst,
    output logic                              s_axis_tlast_timeout,
    input  logic                              tlast_timeout_enable,
    input  logic [12:0]                       timeout_top,
    input  logic                              tsf_pulse_1M,
    input  logic                              tx_done,
    input  logic [14:0]                       count_top,
    output logic                              tx_pkt_intr
);

    localparam int W = MAX_BIT_NUM_DMA_SYMBOL;
    localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
    localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] CNT_TWO  = {{(W-2){1'b0}}, 2'b10};
    localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        HDR0         = 3'd1,
        HDR1         = 3'd2,
        PAYLOAD      = 3'd3,
        DRAIN        = 3'd4,
        WAIT_TX_DONE = 3'd5,
        RST_WAIT     = 3'd6
    } state_t;

    state_t         state_r;
    state_t         next_state_s;

    logic [W-1:0]   timer_r;
    logic [W-1:0]   word_cnt_r;
    logic [W-1:0]   payload_exp_r;
    logic [2:0]     rst_cnt_r;
    logic           s_axis_rst_r;
    logic           timeout_pulse_r;
    logic [15:0]    pkt_len_r;
    logic [7:0]     pkt_rate_r;
    logic           ht_sgi_r;
    logic           header_valid_r;
    logic [W-1:0]   num_exp_r;
    logic           len_err_r;
    logic [14:0]    intr_cnt_r;
    logic           intr_active_r;
    logic           intr_r;

    logic           tready_s;
    logic           dvalid_s;
    logic           hs_s;
    logic           timeout_s;
    logic           timer_active_s;
    logic           last_word_s;
    logic           set_len_err_s;
    logic [W-1:0]   hdr_ceil_s;

    assign hdr_ceil_s  = {{(W-13){1'b0}}, s_axis.tdata[15:3]}
                       + {{(W-1){1'b0}}, (s_axis.tdata[2:0] != 3'b000)};
    assign last_word_s = ((word_cnt_r + CNT_ONE) == payload_exp_r);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state, ready/valid decode and timeout override
    always_comb begin
        next_state_s   = state_r;
        tready_s       = 1'b0;
        dvalid_s       = 1'b0;
        set_len_err_s  = 1'b0;
        timer_active_s = (state_r == HDR0) || (state_r == HDR1) ||
                         (state_r == PAYLOAD) || (state_r == DRAIN);
        timeout_s      = timer_active_s && tlast_timeout_enable &&
                         (timer_r > {{(W-13){1'b0}}, timeout_top});
        case (state_r)
            IDLE: begin
                if (s_axis.tvalid) next_state_s = HDR0;
                else               next_state_s = IDLE;
            end
            HDR0: begin
                tready_s = 1'b1;
                if (s_axis.tvalid) next_state_s = HDR1;
                else               next_state_s = HDR0;
            end
            HDR1: begin
                tready_s = 1'b1;
                if (s_axis.tvalid) begin
                    if (payload_exp_r == CNT_ZERO) begin
                        if (s_axis.tlast) begin
                            next_state_s = WAIT_TX_DONE;
                        end else begin
                            set_len_err_s = 1'b1;
                            next_state_s  = DRAIN;
                        end
                    end else if (s_axis.tlast) begin
                        set_len_err_s = 1'b1;
                        next_state_s  = WAIT_TX_DONE;
                    end else begin
                        next_state_s = PAYLOAD;
                    end
                end else begin
                    next_state_s = HDR1;
                end
            end
            PAYLOAD: begin
                tready_s = acc_ready;
                dvalid_s = s_axis.tvalid;
                if (s_axis.tvalid && acc_ready) begin
                    if (last_word_s) begin
                        if (s_axis.tlast) begin
                            next_state_s = WAIT_TX_DONE;
                        end else begin
                            set_len_err_s = 1'b1;
                            next_state_s  = DRAIN;
                        end
                    end else if (s_axis.tlast) begin
                        set_len_err_s = 1'b1;
                        next_state_s  = WAIT_TX_DONE;
                    end else begin
                        next_state_s = PAYLOAD;
                    end
                end else begin
                    next_state_s = PAYLOAD;
                end
            end
            DRAIN: begin
                tready_s = 1'b1;
                if (s_axis.tvalid && s_axis.tlast) next_state_s = WAIT_TX_DONE;
                else                               next_state_s = DRAIN;
            end
            WAIT_TX_DONE: begin
                if (tx_done) next_state_s = IDLE;
                else         next_state_s = WAIT_TX_DONE;
            end
            RST_WAIT: begin
                if (rst_cnt_r == 3'd7) next_state_s = IDLE;
                else                   next_state_s = RST_WAIT;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
        // A timeout wins over any handshake offered in the same cycle
        if (timeout_s) begin
            next_state_s  = RST_WAIT;
            tready_s      = 1'b0;
            dvalid_s      = 1'b0;
            set_len_err_s = 1'b0;
        end else begin
            next_state_s = next_state_s;
        end
        hs_s = s_axis.tvalid && tready_s;
    end

    // Timer, payload word counter and local stream reset sequencing
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            timer_r         <= CNT_ZERO;
            word_cnt_r      <= CNT_ZERO;
            rst_cnt_r       <= 3'd0;
            s_axis_rst_r    <= 1'b0;
            timeout_pulse_r <= 1'b0;
        end else begin
            timeout_pulse_r <= timeout_s;
            if (state_r == IDLE) begin
                timer_r    <= CNT_ZERO;
                word_cnt_r <= CNT_ZERO;
            end else begin
                if (timer_active_s && tsf_pulse_1M && (timer_r != CNT_MAX)) begin
                    timer_r <= timer_r + CNT_ONE;
                end
                if ((state_r == PAYLOAD) && hs_s) begin
                    word_cnt_r <= word_cnt_r + CNT_ONE;
                end
            end
            if (timeout_s) begin
                s_axis_rst_r <= 1'b1;
                rst_cnt_r    <= 3'd0;
            end else if (state_r == RST_WAIT) begin
                rst_cnt_r <= rst_cnt_r + 3'd1;
                if (rst_cnt_r == 3'd7) s_axis_rst_r <= 1'b0;
            end else if (state_r == IDLE) begin
                s_axis_rst_r <= 1'b0;
            end
        end
    end

    // Header capture and sticky length error
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pkt_len_r      <= 16'd0;
            pkt_rate_r     <= 8'd0;
            ht_sgi_r       <= 1'b0;
            header_valid_r <= 1'b0;
            num_exp_r      <= CNT_ZERO;
            payload_exp_r  <= CNT_ZERO;
            len_err_r      <= 1'b0;
        end else begin
            header_valid_r <= (state_r == HDR0) && hs_s;
            if ((state_r == HDR0) && hs_s) begin
                pkt_len_r     <= s_axis.tdata[15:0];
                pkt_rate_r    <= {s_axis.tdata[20], 3'b000, s_axis.tdata[19:16]};
                ht_sgi_r      <= s_axis.tdata[21];
                payload_exp_r <= hdr_ceil_s;
                num_exp_r     <= hdr_ceil_s + CNT_TWO;
                len_err_r     <= 1'b0;
            end else if (set_len_err_s) begin
                len_err_r <= 1'b1;
            end
        end
    end

    // Interrupt delay: restarted by every tx_done, stops after the single match cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            intr_cnt_r    <= 15'd0;
            intr_active_r <= 1'b0;
            intr_r        <= 1'b0;
        end else if (tx_done) begin
            intr_cnt_r    <= 15'd0;
            intr_active_r <= 1'b1;
            intr_r        <= (count_top == 15'd0);
        end else if (intr_active_r && (intr_cnt_r != count_top)) begin
            intr_cnt_r <= intr_cnt_r + 15'd1;
            intr_r     <= ((intr_cnt_r + 15'd1) == count_top);
        end else begin
            intr_active_r <= 1'b0;
            intr_r        <= 1'b0;
        end
    end

    assign s_axis.tready           = tready_s;
    assign data_to_acc             = s_axis.tdata;
    assign data_valid_to_acc       = dvalid_s;
    assign pkt_len                 = pkt_len_r;
    assign pkt_rate                = pkt_rate_r;
    assign ht_sgi                  = ht_sgi_r;
    assign header_valid            = header_valid_r;
    assign num_dma_symbol_expected = num_exp_r;
    assign len_err                 = len_err_r;
    assign s_axis_rst              = s_axis_rst_r;
    assign s_axis_tlast_timeout    = timeout_pulse_r;
    assign tx_pkt_intr             = intr_r;

endmodule
